// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done handshake.
// Results above MAX_VAL saturate to 9999 and raise overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam int          WORK_W    = BIN_W + 16;
  localparam logic [4:0]  LAST_ITER = 5'(BIN_W - 1);
  localparam logic [31:0] MAX_U     = MAX_VAL;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] work_d;
  logic [15:0]       bcdAdj;
  logic [4:0]        iter_q;
  logic              sat_q;
  logic              satIn;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [3:0]        ones_q;
  logic [3:0]        tens_q;
  logic [3:0]        hundreds_q;
  logic [3:0]        thousands_q;

  // Folds to constant 0 when BIN_W is too narrow to exceed MAX_VAL.
  assign satIn = (32'(bin_in) > MAX_U);

  always_comb begin
    bcdAdj = '0;
    for (int i = 0; i < 4; i++) begin
      if (work_q[BIN_W+4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = work_q[BIN_W+4*i +: 4] + 4'd3;
      end else begin
        bcdAdj[4*i +: 4] = work_q[BIN_W+4*i +: 4];
      end
    end
    work_d = {bcdAdj[14:0], work_q[BIN_W-1:0], 1'b0};
  end

  // busy stays high through the done cycle so the producer sees one unbroken window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      iter_q      <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ones_q      <= '0;
      tens_q      <= '0;
      hundreds_q  <= '0;
      thousands_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            work_q  <= {16'h0000, bin_in};
            sat_q   <= satIn;
            iter_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          busy_q <= 1'b1;
          work_q <= work_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == LAST_ITER) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b1;
          done_q <= 1'b1;
          if (sat_q) begin
            ones_q      <= 4'd9;
            tens_q      <= 4'd9;
            hundreds_q  <= 4'd9;
            thousands_q <= 4'd9;
            ovf_q       <= 1'b1;
          end else begin
            ones_q      <= work_q[BIN_W    +: 4];
            tens_q      <= work_q[BIN_W+4  +: 4];
            hundreds_q  <= work_q[BIN_W+8  +: 4];
            thousands_q <= work_q[BIN_W+12 +: 4];
            ovf_q       <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign ones      = ones_q;
  assign tens      = tens_q;
  assign hundreds  = hundreds_q;
  assign thousands = thousands_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised, self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int LATENCY = BIN_W + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [3:0]       thousands;

  int vecCount = 0;
  int errCount = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {overflow, thousands, hundreds, tens, ones} expected for a given input value.
  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [16:0] observed();
    return {overflow, thousands, hundreds, tens, ones};
  endfunction

  task automatic accept(input int v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Waits for done (bounded), counting edges since accept and busy-high cycles.
  task automatic waitDone(output int edges, output int busyCnt, output bit stable);
    logic [16:0] snap;
    snap    = observed();
    edges   = -1;
    busyCnt = busy ? 1 : 0;
    stable  = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (busy) busyCnt++;
      if (done) begin
        edges = e;
        break;
      end
      if (observed() !== snap) stable = 1'b0;
    end
  endtask

  task automatic convertAndCheck(input int v, input string name);
    int edges, busyCnt;
    bit stable;
    accept(v);
    waitDone(edges, busyCnt, stable);
    vecCount++;
    if (edges !== LATENCY) begin
      errCount++;
      $display("[TB] FAIL %s latency: got %0d edges, want %0d", name, edges, LATENCY);
    end
    vecCount++;
    if (observed() !== model(v)) begin
      errCount++;
      $display("[TB] FAIL %s result (in=%0d): got %h, want %h", name, v, observed(), model(v));
    end
    vecCount++;
    if (!stable) begin
      errCount++;
      $display("[TB] FAIL %s outputs changed before done: got 0, want 1", name);
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (done !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL %s done width: got done=%b after pulse, want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vecCount++;
    if ({busy, done, observed()} !== 19'd0) begin
      errCount++;
      $display("[TB] FAIL reset_state: got %h, want 0", {busy, done, observed()});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int edges, busyCnt;
    bit stable;
    accept(0);
    waitDone(edges, busyCnt, stable);
    vecCount++;
    if (edges !== LATENCY) begin
      errCount++;
      $display("[TB] FAIL zero latency: got %0d, want %0d", edges, LATENCY);
    end
    vecCount++;
    if (busyCnt !== LATENCY + 1) begin
      errCount++;
      $display("[TB] FAIL zero busy_cycles: got %0d, want %0d", busyCnt, LATENCY + 1);
    end
    vecCount++;
    if (observed() !== model(0)) begin
      errCount++;
      $display("[TB] FAIL zero result: got %h, want %h", observed(), model(0));
    end
    @(posedge clk);
    #1;
    vecCount++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL zero idle_after: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_known();
    convertAndCheck(1234, "k1234");
    convertAndCheck(9999, "k9999");
    convertAndCheck(10000, "k10000");
    convertAndCheck(16383, "k16383");
    convertAndCheck(42, "k42");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      convertAndCheck(int'($urandom_range(0, 16383)), "rand");
    end
  endtask

  task automatic test_ignore_start();
    int doneCount = 0;
    int doneEdge  = -1;
    logic [16:0] atDone = '0;
    accept(507);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        doneEdge = e;
        atDone   = observed();
      end
      if (e == 4) begin
        start  = 1'b1;
        bin_in = BIN_W'(88);
      end else if (e == 5) begin
        start  = 1'b0;
        bin_in = BIN_W'($urandom_range(0, 16383));
      end
    end
    vecCount++;
    if (doneCount !== 1) begin
      errCount++;
      $display("[TB] FAIL ignore done_count: got %0d, want 1", doneCount);
    end
    vecCount++;
    if (doneEdge !== LATENCY) begin
      errCount++;
      $display("[TB] FAIL ignore done_edge: got %0d, want %0d", doneEdge, LATENCY);
    end
    vecCount++;
    if (atDone !== model(507)) begin
      errCount++;
      $display("[TB] FAIL ignore result: got %h, want %h", atDone, model(507));
    end
  endtask

  // With start held high, accepts land every LATENCY+1 edges starting at edge 0.
  task automatic test_back_to_back();
    int base;
    int doneSeen = 0;
    base = int'($urandom_range(0, 16000));
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(base);
    for (int k = 0; k < 4 * (LATENCY + 1); k++) begin
      @(posedge clk);
      #1;
      bin_in = BIN_W'(base + k + 1);
      vecCount++;
      if (done !== ((k % (LATENCY + 1)) == LATENCY)) begin
        errCount++;
        $display("[TB] FAIL b2b done@%0d: got %b, want %b", k, done,
                 (k % (LATENCY + 1)) == LATENCY);
      end
      if (done) begin
        doneSeen++;
        vecCount++;
        if (observed() !== model(base + k - LATENCY)) begin
          errCount++;
          $display("[TB] FAIL b2b result@%0d: got %h, want %h", k, observed(),
                   model(base + k - LATENCY));
        end
      end
    end
    start = 1'b0;
    vecCount++;
    if (doneSeen !== 4) begin
      errCount++;
      $display("[TB] FAIL b2b done_total: got %0d, want 4", doneSeen);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int sawDone = 0;
    accept(4321);
    repeat (6) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vecCount++;
    if ({busy, done, observed()} !== 19'd0) begin
      errCount++;
      $display("[TB] FAIL reset_mid outputs: got %h, want 0", {busy, done, observed()});
    end
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done) sawDone++;
      if (e == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    vecCount++;
    if (sawDone !== 0) begin
      errCount++;
      $display("[TB] FAIL reset_mid done_pulses: got %0d, want 0", sawDone);
    end
    convertAndCheck(60, "after_reset60");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
